// File: rtl/relu_maxpool_pkg.sv
// Shared types, saturation limits and requantisation helpers for the
// activation/pooling stage and later layers.
package relu_maxpool_pkg;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned PIX_W = 16;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [PIX_W-1:0] pix_t;

  localparam pix_t PIX_MAX = 16'sh7FFF;
  localparam pix_t PIX_MIN = 16'sh8000;

  // Arithmetic shift of the accumulator, then clamp into the 16-bit pixel range.
  function automatic pix_t requant_sat(input acc_t acc, input int unsigned shift);
    acc_t q;
    pix_t r;
    q = acc >>> shift;
    if (q > acc_t'(PIX_MAX)) begin
      r = PIX_MAX;
    end else if (q < acc_t'(PIX_MIN)) begin
      r = PIX_MIN;
    end else begin
      r = pix_t'(q);
    end
    return r;
  endfunction

  function automatic pix_t pix_max(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// Pixel-in / memory-write-out bundle of the relu_maxpool stage.
interface relu_maxpool_if import relu_maxpool_pkg::*; #(
  parameter int unsigned ADDR_W = 14
) ();

  logic [ADDR_W-1:0] base_result_addr;
  logic              pix_valid;
  acc_t              pix_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  pix_t              wr_data;
  logic              frame_done;

  modport master (
    output base_result_addr, pix_valid, pix_in,
    input  wr_en, wr_addr, wr_data, frame_done
  );

  modport slave (
    input  base_result_addr, pix_valid, pix_in,
    output wr_en, wr_addr, wr_data, frame_done
  );

endinterface

// File: rtl/relu_maxpool_pool_line_buffer.sv
// Holds the horizontal pair maxima of the even row until the odd row arrives.
// Synchronous write, combinational read, cleared on reset.
module pool_line_buffer import relu_maxpool_pkg::*; #(
  parameter int unsigned DEPTH = 23,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  pix_t             wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output pix_t             rd_data
);

  pix_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else if (wr_en && (32'(wr_idx) < DEPTH)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/relu_maxpool.sv
// Requantise + optional ReLU + streaming 2x2 max-pool with pooled-map writes.
// Define RELU_MAXPOOL_RELU_EN to clamp negative activations to zero.
module relu_maxpool import relu_maxpool_pkg::*; #(
  parameter int unsigned IMG_SIZE   = 46,
  parameter int unsigned FRAC_SHIFT = 8,
  parameter int unsigned ADDR_W     = 14
) (
  input  logic           clk,
  input  logic           rst,
  relu_maxpool_if.slave  io
);

  localparam int unsigned P      = IMG_SIZE / 2;
  localparam int unsigned NPOOL  = P * P;
  localparam int unsigned CNT_W  = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
  localparam int unsigned IDX_W  = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned POOL_W = (NPOOL > 1) ? $clog2(NPOOL) : 1;

  logic [CNT_W-1:0]  row, col;
  logic [POOL_W-1:0] pool_idx;
  logic [ADDR_W-1:0] base_q;
  pix_t              held;

  pix_t              act, pair_max, lb_rd, win_max;
  logic [IDX_W-1:0]  lb_idx;
  logic              lb_we, at_origin, col_last, row_last, pool_last, win_done;

  logic              wr_en_q, frame_done_q;
  logic [ADDR_W-1:0] wr_addr_q;
  pix_t              wr_data_q;

  always_comb begin
    act = requant_sat(io.pix_in, FRAC_SHIFT);
`ifdef RELU_MAXPOOL_RELU_EN
    if (act[PIX_W-1]) act = '0;
`endif
    pair_max  = pix_max(held, act);
    win_max   = pix_max(pair_max, lb_rd);
    lb_idx    = IDX_W'(col >> 1);
    lb_we     = io.pix_valid && col[0] && !row[0];
    win_done  = col[0] && row[0];
    at_origin = (row == '0) && (col == '0);
    col_last  = (col == CNT_W'(IMG_SIZE - 1));
    row_last  = (row == CNT_W'(IMG_SIZE - 1));
    pool_last = (pool_idx == POOL_W'(NPOOL - 1));
  end

  pool_line_buffer #(
    .DEPTH (P),
    .IDX_W (IDX_W)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (lb_we),
    .wr_idx  (lb_idx),
    .wr_data (pair_max),
    .rd_idx  (lb_idx),
    .rd_data (lb_rd)
  );

  // Odd sizes need no special casing: the trailing even row/col never hits win_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      row          <= '0;
      col          <= '0;
      pool_idx     <= '0;
      base_q       <= '0;
      held         <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (io.pix_valid) begin
        if (at_origin) base_q <= io.base_result_addr;
        if (!col[0]) held <= act;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (win_done) begin
          wr_en_q      <= 1'b1;
          wr_data_q    <= win_max;
          wr_addr_q    <= base_q + ADDR_W'(pool_idx);
          frame_done_q <= pool_last;
          pool_idx     <= pool_last ? '0 : pool_idx + 1'b1;
        end
      end
    end
  end

  assign io.wr_en      = wr_en_q;
  assign io.wr_addr    = wr_addr_q;
  assign io.wr_data    = wr_data_q;
  assign io.frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: four instances cover the small-map, saturation,
// odd-size and full-size back-to-back cases.
module tb_relu_maxpool;
  import relu_maxpool_pkg::*;

`ifdef RELU_MAXPOOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    int addr;
    int data;
    bit en;
    bit done;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pv;
  logic [31:0] pin;
  logic [13:0] base;
  int          sel;

  int n_checks = 0;
  int n_pass   = 0;

  wr_t qa[$], qb[$], qc[$], qd[$];

  always #5 clk = ~clk;

  relu_maxpool_if #(.ADDR_W(14)) ifa ();
  relu_maxpool_if #(.ADDR_W(14)) ifb ();
  relu_maxpool_if #(.ADDR_W(14)) ifc ();
  relu_maxpool_if #(.ADDR_W(14)) ifd ();

  assign ifa.pix_valid = pv && (sel == 0);
  assign ifb.pix_valid = pv && (sel == 1);
  assign ifc.pix_valid = pv && (sel == 2);
  assign ifd.pix_valid = pv && (sel == 3);
  assign ifa.pix_in = pin;
  assign ifb.pix_in = pin;
  assign ifc.pix_in = pin;
  assign ifd.pix_in = pin;
  assign ifa.base_result_addr = base;
  assign ifb.base_result_addr = base;
  assign ifc.base_result_addr = base;
  assign ifd.base_result_addr = base;

  relu_maxpool #(.IMG_SIZE(4),  .FRAC_SHIFT(0), .ADDR_W(14)) dut_a (.clk(clk), .rst(rst), .io(ifa));
  relu_maxpool #(.IMG_SIZE(4),  .FRAC_SHIFT(8), .ADDR_W(14)) dut_b (.clk(clk), .rst(rst), .io(ifb));
  relu_maxpool #(.IMG_SIZE(5),  .FRAC_SHIFT(0), .ADDR_W(14)) dut_c (.clk(clk), .rst(rst), .io(ifc));
  relu_maxpool #(.IMG_SIZE(46), .FRAC_SHIFT(8), .ADDR_W(14)) dut_d (.clk(clk), .rst(rst), .io(ifd));

  function automatic wr_t mk(input logic [13:0] a, input pix_t d, input logic en, input logic dn);
    wr_t w;
    w.addr = int'(a);
    w.data = int'(d);
    w.en   = en;
    w.done = dn;
    return w;
  endfunction

  always @(negedge clk) begin
    if (ifa.wr_en || ifa.frame_done) qa.push_back(mk(ifa.wr_addr, ifa.wr_data, ifa.wr_en, ifa.frame_done));
    if (ifb.wr_en || ifb.frame_done) qb.push_back(mk(ifb.wr_addr, ifb.wr_data, ifb.wr_en, ifb.frame_done));
    if (ifc.wr_en || ifc.frame_done) qc.push_back(mk(ifc.wr_addr, ifc.wr_data, ifc.wr_en, ifc.frame_done));
    if (ifd.wr_en || ifd.frame_done) qd.push_back(mk(ifd.wr_addr, ifd.wr_data, ifd.wr_en, ifd.frame_done));
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One pixel per call; consecutive calls give back-to-back pix_valid.
  task automatic send(input logic [31:0] v);
    pv  = 1'b1;
    pin = v;
    @(negedge clk);
    pv  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input wr_t q[$], input int first,
                             input int base_addr, input int exp[$]);
    for (int k = 0; k < exp.size(); k++) begin
      if (first + k < q.size()) begin
        check($sformatf("%s_addr%0d", tag, k), q[first+k].addr, (base_addr + k) % 16384);
        check($sformatf("%s_data%0d", tag, k), q[first+k].data, exp[k]);
        check($sformatf("%s_en%0d",   tag, k), q[first+k].en, 1);
        check($sformatf("%s_done%0d", tag, k), q[first+k].done, (k == exp.size() - 1) ? 1 : 0);
      end else begin
        check($sformatf("%s_missing%0d", tag, k), 0, 1);
      end
    end
  endtask

  function automatic int vd(input int f, input int r, input int c);
    return ((r * (7 + 4 * f) + c * (13 - 2 * f)) % 101) - 20;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  initial begin
    int exp[$];
    int pat[16];
    int m;

    sel = 0; pv = 1'b0; pin = '0; base = '0; rst = 1'b1;
    idle(3);

    check("rst_a_wr_en", ifa.wr_en, 0);
    check("rst_a_wr_addr", ifa.wr_addr, 0);
    check("rst_a_wr_data", ifa.wr_data, 0);
    check("rst_a_frame_done", ifa.frame_done, 0);
    check("rst_d_wr_en", ifd.wr_en, 0);
    check("rst_d_wr_addr", ifd.wr_addr, 0);
    check("rst_d_wr_data", ifd.wr_data, 0);
    check("rst_d_frame_done", ifd.frame_done, 0);
    rst = 1'b0;

    // 4x4 raster 1..16: write strobe exactly one cycle after each window completes.
    sel = 0; base = 14'd10000;
    for (int i = 1; i <= 16; i++) begin
      send(32'(i));
      check($sformatf("t1_lat%0d", i), ifa.wr_en, (i == 6 || i == 8 || i == 14 || i == 16) ? 1 : 0);
    end
    idle(3);
    check("t1_count", qa.size(), 4);
    exp = '{6, 8, 14, 16};
    check_frame("t1", qa, 0, 10000, exp);
    qa.delete();

    // Maxima in each window position, with gaps between pixels.
    base = 14'd20;
    pat = '{9, 1, 2, 20, 4, 5, 6, 7, 1, 2, 3, 4, 30, 2, 3, 40};
    for (int i = 0; i < 16; i++) begin
      send(32'(pat[i]));
      idle(i % 3);
    end
    idle(3);
    check("t2_count", qa.size(), 4);
    exp = '{9, 20, 30, 40};
    check_frame("t2", qa, 0, 20, exp);
    qa.delete();

    // Abort mid-frame; a pixel presented during reset is dropped.
    base = 14'd5000;
    for (int i = 1; i <= 7; i++) send(32'(i));
    rst = 1'b1; pv = 1'b1; pin = 32'd99;
    @(negedge clk);
    pv = 1'b0; rst = 1'b0;
    check("t3_rst_wr_en", ifa.wr_en, 0);
    check("t3_rst_frame_done", ifa.frame_done, 0);
    qa.delete();
    base = 14'd10000;
    for (int i = 1; i <= 16; i++) send(32'(i));
    idle(3);
    check("t3_count", qa.size(), 4);
    exp = '{6, 8, 14, 16};
    check_frame("t3", qa, 0, 10000, exp);
    qa.delete();

    // Saturation and ReLU, three frames back-to-back.
    sel = 1;
    base = 14'd100;
    for (int i = 0; i < 16; i++) send(32'h7FFF_FFFF);
    base = 14'd200;
    for (int i = 0; i < 16; i++) send(32'h8000_0000);
    base = 14'd300;
    for (int i = 0; i < 16; i++) send(32'hFFFF_FF00);
    idle(3);
    check("t4_count", qb.size(), 12);
    exp = '{32767, 32767, 32767, 32767};
    check_frame("t4_pos", qb, 0, 100, exp);
    m = RELU ? 0 : -32768;
    exp = '{m, m, m, m};
    check_frame("t4_neg", qb, 4, 200, exp);
    m = RELU ? 0 : -1;
    exp = '{m, m, m, m};
    check_frame("t4_relu", qb, 8, 300, exp);

    // Odd size: last row/column discarded.
    sel = 2; base = 14'd50;
    for (int i = 1; i <= 25; i++) begin
      send(32'(i));
      idle($urandom_range(0, 2));
    end
    idle(3);
    check("t5_count", qc.size(), 4);
    exp = '{7, 9, 17, 19};
    check_frame("t5", qc, 0, 50, exp);

    // Two full frames back-to-back; base changes mid-frame 0 take effect only at frame 1.
    sel = 3; base = 14'd10000;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 46; r++) begin
        for (int c = 0; c < 46; c++) begin
          if (f == 0 && r == 20 && c == 0) base = 14'd12000;
          send(32'(vd(f, r, c) * 256));
        end
      end
    end
    idle(3);
    check("t6_count", qd.size(), 1058);
    for (int f = 0; f < 2; f++) begin
      exp.delete();
      for (int i = 0; i < 23; i++) begin
        for (int j = 0; j < 23; j++) begin
          m = imax(imax(vd(f, 2*i, 2*j), vd(f, 2*i, 2*j+1)),
                   imax(vd(f, 2*i+1, 2*j), vd(f, 2*i+1, 2*j+1)));
          if (RELU && m < 0) m = 0;
          exp.push_back(m);
        end
      end
      check_frame($sformatf("t6_f%0d", f), qd, f * 529, (f == 0) ? 10000 : 12000, exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Streaming activation and 2x2 max-pool stage directly downstream of the 2-D convolution engine. Consumes the 32-bit accumulated convolution result pixels as the engine emits them (one pulse per finished pixel, raster order), requantises each to signed 16-bit, applies ReLU, and reduces each 2x2 window to its maximum. Pooled pixels are written to the global memory pool as 16-bit words at a configurable base address, forming the next layer's input feature map.

## Interface
- IMG_SIZE, 46, width/height of the square convolution output map (48 input, 3x3 kernel)
- FRAC_SHIFT, 8, arithmetic right shift applied to the 32-bit accumulator before saturation
- ADDR_W, 14, memory address width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- base_result_addr  in  ADDR_W  first write address of the pooled map; sampled on the first pixel of each frame
- pix_valid  in  1  one-cycle pulse: pix_in holds a finished convolution pixel
- pix_in  in  32  signed convolution accumulator
- wr_en  out  1  one-cycle memory write strobe
- wr_addr  out  ADDR_W  memory write address
- wr_data  out  16  pooled pixel, signed
- frame_done  out  1  one-cycle pulse after the final pooled pixel of a frame is written

## Operation
- Counters row, col in 0..IMG_SIZE-1; advance on each pix_valid, col first; col wraps to 0 and row increments; after (IMG_SIZE-1, IMG_SIZE-1) both wrap to 0.
- Requantise: q = pix_in >>> FRAC_SHIFT (arithmetic); saturate to [-32768, 32767].
- ReLU (see Configuration): a = (q < 0) ? 0 : q.
- Pair register: on even col, hold a; on odd col, m = max(held, a) (signed compare).
- Even row, odd col: line buffer[col>>1] <= m.
- Odd row, odd col: result = max(m, line buffer[col>>1]); issue write.
- P = IMG_SIZE/2 (floor). Odd IMG_SIZE: last column and last row never reach a write and are discarded.
- Write address = latched base + pooled index; pooled index counts 0..P*P-1 and resets at frame start. Address arithmetic wraps modulo 2^ADDR_W.
- frame_done pulses with the write of pooled index P*P-1; counters are then at 0 ready for the next frame with no idle gap required.
- No backpressure: the memory write port accepts every strobe.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0; row/col/pooled index=0; pair register and line buffer=0.
- Latency: wr_en/wr_addr/wr_data registered, asserted the cycle after the pix_valid completing a window.
- pix_valid may be asserted every cycle (back-to-back) or with arbitrary gaps; behaviour identical.
- pix_valid ignored in the cycle rst is high; rst mid-frame aborts the frame, no frame_done, next pix_valid is treated as (0,0).
- base_result_addr is sampled only when pix_valid arrives at (0,0); changes mid-frame have no effect.
- frame_done coincides with last wr_en cycle (same clock).

## Configuration
- RELU_MAXPOOL_RELU_EN defined: ReLU applied, negative quantised values become 0, wr_data never negative.
- Not defined: ReLU stage bypassed, signed max pooling over raw quantised values; negative outputs possible. All other behaviour unchanged.

## Structure
- Shared package: ACC_W=32, PIX_W=16, PIX_MAX/PIX_MIN saturation constants, requantise-and-saturate function used also by future layers.
- One sub-module: pool_line_buffer, P entries x 16 bits, one synchronous write port, one combinational read port indexed by col>>1, cleared on rst.

## Test plan
- IMG_SIZE=4, FRAC_SHIFT=0, base 10000, inputs 1..16 raster -> writes (10000,6),(10001,8),(10002,14),(10003,16); frame_done with the last.
- Saturation: FRAC_SHIFT=8, pix_in=0x7FFFFFFF in every window -> wr_data=32767; pix_in=-2^31 with RELU_EN off -> -32768.
- ReLU: all inputs -256, FRAC_SHIFT=8 -> wr_data=0 with macro, -1 without.
- IMG_SIZE=5, 25 pixels -> exactly 4 writes, row 4/col 4 ignored, frame_done on the 4th.
- Reset after 7 of 16 pixels (IMG_SIZE=4), then full frame 1..16 -> only the 4 expected writes, addresses from 10000.
- Back-to-back two frames of default IMG_SIZE=46 with base 10000 then 12000 -> 529 writes each, frame_done twice, second frame addresses 12000..12528.
